bus_datapath: RTL and testbench

Parametrised single-bus CPU datapath: a register file plus PC, IR, Y, HI, LO, MAR, MDR and a double-width Z, all sharing one encoded-select bus. It adds an on-block ALU feeding Z and a req/ack memory-read sequencer for MDR that stalls register writes while busy. It sits between the control unit, which drives select, enable and op fields each cycle, and the memory interface.

---
 rtl/bus_datapath_pkg.sv | 40 ++++
 rtl/bus_datapath_alu.sv | 54 +++++
 rtl/bus_datapath.sv | 199 +++++++++++++++++++
 tb/tb_bus_datapath.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_datapath_pkg.sv
// Shared definitions for the single-bus datapath.
//   - Bus source-code offsets, relative to NUM_REGS (codes below NUM_REGS are registers).
//   - ALU operation and memory-sequencer state encodings.
//   - sel_width(): width of the encoded bus source select.
package bus_datapath_pkg;

   localparam int SRC_HI     = 0;
   localparam int SRC_LO     = 1;
   localparam int SRC_ZHI    = 2;
   localparam int SRC_ZLO    = 3;
   localparam int SRC_PC     = 4;
   localparam int SRC_MDR    = 5;
   localparam int SRC_INPORT = 6;
   localparam int SRC_C      = 7;
   localparam int SRC_IR     = 8;
   localparam int SRC_Y      = 9;
   localparam int SRC_COUNT  = 10;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_NOT = 3'd4,
      ALU_NEG = 3'd5,
      ALU_INC = 3'd6,
      ALU_MUL = 3'd7
   } alu_op_e;

   typedef enum logic {
      MEM_IDLE = 1'b0,
      MEM_REQ  = 1'b1
   } mem_state_e;

   // Enough select bits for all registers plus the ten special sources.
   function automatic int sel_width(input int num_regs);
      return $clog2(num_regs + SRC_COUNT);
   endfunction

endpackage

// File: rtl/bus_datapath_alu.sv
// Combinational ALU feeding the double-width Z register.
//   a_i      : A operand (Y register)
//   b_i      : B operand (bus)
//   op_i     : operation
//   result_o : {ZHI, ZLO}; ZHI is zero except for MUL
module bus_alu
   import bus_datapath_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]   a_i,
   input  logic [DATA_W-1:0]   b_i,
   input  alu_op_e             op_i,
   output logic [2*DATA_W-1:0] result_o
);

   logic [2*DATA_W-1:0] a_ext_s;
   logic [2*DATA_W-1:0] b_ext_s;
   logic [2*DATA_W-1:0] prod_s;
   logic [DATA_W-1:0]   lo_s;

   // Signed product: sign-extend both operands to full width, then the low
   // 2*DATA_W bits of an unsigned multiply are the signed product.
   always_comb begin
      a_ext_s = {{DATA_W{a_i[DATA_W-1]}}, a_i};
      b_ext_s = {{DATA_W{b_i[DATA_W-1]}}, b_i};
      prod_s  = a_ext_s * b_ext_s;
   end

   // Single-width operations; all wrap modulo 2^DATA_W.
   always_comb begin
      lo_s = '0;
      case (op_i)
         ALU_ADD: lo_s = a_i + b_i;
         ALU_SUB: lo_s = a_i - b_i;
         ALU_AND: lo_s = a_i & b_i;
         ALU_OR:  lo_s = a_i | b_i;
         ALU_NOT: lo_s = ~b_i;
         ALU_NEG: lo_s = {DATA_W{1'b0}} - b_i;
         ALU_INC: lo_s = b_i + {{(DATA_W-1){1'b0}}, 1'b1};
         default: lo_s = '0;
      endcase
   end

   // Result selection: MUL uses the whole product, everything else zero-fills ZHI.
   always_comb begin
      if (op_i == ALU_MUL) begin
         result_o = prod_s;
      end else begin
         result_o = {{DATA_W{1'b0}}, lo_s};
      end
   end

endmodule

// File: rtl/bus_datapath.sv
// Single-bus CPU datapath: register file, PC, IR, Y, HI, LO, MAR, MDR and a
// double-width Z share one encoded-select bus. Z is loaded from the ALU
// (A = Y, B = bus); MDR is additionally filled by a req/ack memory read.
//   clock/clear      : clock, synchronous active-high reset
//   src_sel          : bus source code (registers, then HI..Y, else 0)
//   reg_in, *_in     : destination write enables, all load bus_out
//   alu_op           : ALU operation applied on z_in
//   mem_read         : start read at MAR into MDR
//   inport_data      : INPORT bus source
//   mem_rdata/ack    : read completion from memory
//   bus_out          : current bus value (combinational)
//   mem_addr         : MAR contents
//   mem_req, busy    : read outstanding (registered)
module bus_datapath
   import bus_datapath_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int IMM_W    = 19,
   parameter int R0_ZERO  = 0,
   localparam int SEL_W   = sel_width(NUM_REGS)
) (
   input  logic                clock,
   input  logic                clear,
   input  logic [SEL_W-1:0]    src_sel,
   input  logic [NUM_REGS-1:0] reg_in,
   input  logic                pc_in,
   input  logic                ir_in,
   input  logic                y_in,
   input  logic                hi_in,
   input  logic                lo_in,
   input  logic                mar_in,
   input  logic                mdr_in,
   input  logic                z_in,
   input  logic [2:0]          alu_op,
   input  logic                mem_read,
   input  logic [DATA_W-1:0]   inport_data,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ack,
   output logic [DATA_W-1:0]   bus_out,
   output logic [DATA_W-1:0]   mem_addr,
   output logic                mem_req,
   output logic                busy
);

   localparam int IDX_W = $clog2(NUM_REGS);

   localparam logic [SEL_W-1:0] SEL_HI     = SEL_W'(NUM_REGS + SRC_HI);
   localparam logic [SEL_W-1:0] SEL_LO     = SEL_W'(NUM_REGS + SRC_LO);
   localparam logic [SEL_W-1:0] SEL_ZHI    = SEL_W'(NUM_REGS + SRC_ZHI);
   localparam logic [SEL_W-1:0] SEL_ZLO    = SEL_W'(NUM_REGS + SRC_ZLO);
   localparam logic [SEL_W-1:0] SEL_PC     = SEL_W'(NUM_REGS + SRC_PC);
   localparam logic [SEL_W-1:0] SEL_MDR    = SEL_W'(NUM_REGS + SRC_MDR);
   localparam logic [SEL_W-1:0] SEL_INPORT = SEL_W'(NUM_REGS + SRC_INPORT);
   localparam logic [SEL_W-1:0] SEL_C      = SEL_W'(NUM_REGS + SRC_C);
   localparam logic [SEL_W-1:0] SEL_IR     = SEL_W'(NUM_REGS + SRC_IR);
   localparam logic [SEL_W-1:0] SEL_Y      = SEL_W'(NUM_REGS + SRC_Y);
   localparam logic [SEL_W-1:0] SEL_NREGS  = SEL_W'(NUM_REGS);

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [DATA_W-1:0]   pc_q, pc_d, ir_q, ir_d, y_q, y_d;
   logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d, mar_q, mar_d, mdr_q, mdr_d;
   logic [2*DATA_W-1:0] z_q, z_d;
   logic [2*DATA_W-1:0] alu_res_s;
   logic [DATA_W-1:0]   bus_s;
   logic [DATA_W-1:0]   c_s;
   logic                wr_ok_s;
   mem_state_e          state_q;
   logic                mem_req_q;
   logic                busy_q;

   // Immediate constant: low IMM_W bits of IR, sign-extended.
   assign c_s = {{(DATA_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};

   // Destination writes are only honoured while no memory read is outstanding.
   assign wr_ok_s = (state_q == MEM_IDLE);

   // Bus source multiplexer; unused codes and a hard-wired R0 drive zero.
   always_comb begin
      bus_s = '0;
      case (src_sel)
         SEL_HI:     bus_s = hi_q;
         SEL_LO:     bus_s = lo_q;
         SEL_ZHI:    bus_s = z_q[2*DATA_W-1:DATA_W];
         SEL_ZLO:    bus_s = z_q[DATA_W-1:0];
         SEL_PC:     bus_s = pc_q;
         SEL_MDR:    bus_s = mdr_q;
         SEL_INPORT: bus_s = inport_data;
         SEL_C:      bus_s = c_s;
         SEL_IR:     bus_s = ir_q;
         SEL_Y:      bus_s = y_q;
         default: begin
            if (src_sel < SEL_NREGS) begin
               if ((R0_ZERO != 0) && (src_sel == {SEL_W{1'b0}})) begin
                  bus_s = '0;
               end else begin
                  bus_s = regs_q[src_sel[IDX_W-1:0]];
               end
            end else begin
               bus_s = '0;
            end
         end
      endcase
   end

   bus_alu #(.DATA_W(DATA_W)) u_alu (
      .a_i      (y_q),
      .b_i      (bus_s),
      .op_i     (alu_op_e'(alu_op)),
      .result_o (alu_res_s)
   );

   // Register-file next state; R0 is never written when it is hard-wired to zero.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = (wr_ok_s && reg_in[i] && !((R0_ZERO != 0) && (i == 0))) ? bus_s : regs_q[i];
      end
   end

   // Special-register next state. A memory ack takes MDR ahead of any bus load
   // (enables are ignored during REQ anyway).
   always_comb begin
      pc_d  = (wr_ok_s && pc_in)  ? bus_s     : pc_q;
      ir_d  = (wr_ok_s && ir_in)  ? bus_s     : ir_q;
      y_d   = (wr_ok_s && y_in)   ? bus_s     : y_q;
      hi_d  = (wr_ok_s && hi_in)  ? bus_s     : hi_q;
      lo_d  = (wr_ok_s && lo_in)  ? bus_s     : lo_q;
      mar_d = (wr_ok_s && mar_in) ? bus_s     : mar_q;
      z_d   = (wr_ok_s && z_in)   ? alu_res_s : z_q;
      mdr_d = ((state_q == MEM_REQ) && mem_ack) ? mem_rdata :
              ((wr_ok_s && mdr_in) ? bus_s : mdr_q);
   end

   // Datapath state registers.
   always_ff @(posedge clock) begin
      if (clear) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         pc_q  <= '0;
         ir_q  <= '0;
         y_q   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         mar_q <= '0;
         mdr_q <= '0;
         z_q   <= '0;
      end else begin
         regs_q <= regs_d;
         pc_q   <= pc_d;
         ir_q   <= ir_d;
         y_q    <= y_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         mar_q  <= mar_d;
         mdr_q  <= mdr_d;
         z_q    <= z_d;
      end
   end

   // Memory-read sequencer with registered req/busy. A clear aborts an
   // outstanding read, so a late ack lands in IDLE and is ignored.
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q   <= MEM_IDLE;
         mem_req_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            MEM_IDLE: begin
               if (mem_read) begin
                  state_q   <= MEM_REQ;
                  mem_req_q <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            MEM_REQ: begin
               if (mem_ack) begin
                  state_q   <= MEM_IDLE;
                  mem_req_q <= 1'b0;
                  busy_q    <= 1'b0;
               end
            end
            default: begin
               state_q   <= MEM_IDLE;
               mem_req_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus_out  = bus_s;
   assign mem_addr = mar_q;
   assign mem_req  = mem_req_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_bus_datapath.sv
module tb_bus_datapath;

   localparam int DW = 32;
   localparam int NR = 16;
   localparam int SW = 5;

   localparam int S_HI = NR + 0, S_LO = NR + 1, S_ZHI = NR + 2, S_ZLO = NR + 3;
   localparam int S_PC = NR + 4, S_MDR = NR + 5, S_IN = NR + 6, S_C = NR + 7;
   localparam int S_IR = NR + 8, S_Y = NR + 9;

   logic          clock;
   logic          clear;
   logic [SW-1:0] src_sel;
   logic [NR-1:0] reg_in;
   logic          pc_in, ir_in, y_in, hi_in, lo_in, mar_in, mdr_in, z_in;
   logic [2:0]    alu_op;
   logic          mem_read;
   logic [DW-1:0] inport_data;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;
   logic [DW-1:0] bus_out;
   logic [DW-1:0] mem_addr;
   logic          mem_req;
   logic          busy;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference state, updated from the architectural rules each cycle.
   logic [DW-1:0] m_regs [NR];
   logic [DW-1:0] m_pc, m_ir, m_y, m_hi, m_lo, m_mar, m_mdr, m_zhi, m_zlo;
   bit            m_busy;

   bus_datapath #(
      .DATA_W(DW), .NUM_REGS(NR), .IMM_W(19), .R0_ZERO(1)
   ) dut (
      .clock(clock), .clear(clear), .src_sel(src_sel), .reg_in(reg_in),
      .pc_in(pc_in), .ir_in(ir_in), .y_in(y_in), .hi_in(hi_in), .lo_in(lo_in),
      .mar_in(mar_in), .mdr_in(mdr_in), .z_in(z_in), .alu_op(alu_op),
      .mem_read(mem_read), .inport_data(inport_data), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .bus_out(bus_out), .mem_addr(mem_addr),
      .mem_req(mem_req), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] m_bus(input int sel);
      if (sel == 0)                 return 32'h0;
      else if (sel < NR)            return m_regs[sel];
      else if (sel == S_HI)         return m_hi;
      else if (sel == S_LO)         return m_lo;
      else if (sel == S_ZHI)        return m_zhi;
      else if (sel == S_ZLO)        return m_zlo;
      else if (sel == S_PC)         return m_pc;
      else if (sel == S_MDR)        return m_mdr;
      else if (sel == S_IN)         return inport_data;
      else if (sel == S_C)          return {{13{m_ir[18]}}, m_ir[18:0]};
      else if (sel == S_IR)         return m_ir;
      else if (sel == S_Y)          return m_y;
      else                          return 32'h0;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
      m_pc = 32'h0; m_ir = 32'h0; m_y = 32'h0; m_hi = 32'h0; m_lo = 32'h0;
      m_mar = 32'h0; m_mdr = 32'h0; m_zhi = 32'h0; m_zlo = 32'h0; m_busy = 1'b0;
   endtask

   task automatic idle_inputs();
      clear = 1'b0; reg_in = '0; pc_in = 1'b0; ir_in = 1'b0; y_in = 1'b0;
      hi_in = 1'b0; lo_in = 1'b0; mar_in = 1'b0; mdr_in = 1'b0; z_in = 1'b0;
      alu_op = 3'd0; mem_read = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
   endtask

   // Advance the model by one clock from the current inputs, clock the DUT,
   // then compare the visible outputs.
   task automatic cycle();
      logic [DW-1:0] b, zh, zl;
      longint        sa, sb, p;
      b = m_bus(int'(src_sel));
      if (clear) begin
         m_reset();
      end else if (!m_busy) begin
         zh = 32'h0;
         case (alu_op)
            3'd0: zl = m_y + b;
            3'd1: zl = m_y - b;
            3'd2: zl = m_y & b;
            3'd3: zl = m_y | b;
            3'd4: zl = ~b;
            3'd5: zl = 32'h0 - b;
            3'd6: zl = b + 32'h1;
            default: begin
               sa = longint'($signed(m_y));
               sb = longint'($signed(b));
               p  = sa * sb;
               zh = p[63:32];
               zl = p[31:0];
            end
         endcase
         if (z_in) begin m_zhi = zh; m_zlo = zl; end
         for (int i = 1; i < NR; i++) if (reg_in[i]) m_regs[i] = b;
         if (pc_in)  m_pc  = b;
         if (ir_in)  m_ir  = b;
         if (y_in)   m_y   = b;
         if (hi_in)  m_hi  = b;
         if (lo_in)  m_lo  = b;
         if (mar_in) m_mar = b;
         if (mdr_in) m_mdr = b;
         if (mem_read) m_busy = 1'b1;
      end else if (mem_ack) begin
         m_mdr  = mem_rdata;
         m_busy = 1'b0;
      end
      @(posedge clock);
      #1;
      check_eq("bus", bus_out, m_bus(int'(src_sel)));
      check_eq("mem_addr", mem_addr, m_mar);
      check_eq("mem_req", {31'h0, mem_req}, {31'h0, m_busy});
      check_eq("busy", {31'h0, busy}, {31'h0, m_busy});
   endtask

   // Put a value onto the bus via INPORT and load the chosen destination(s).
   task automatic load_in(input logic [DW-1:0] v);
      inport_data = v;
      src_sel     = SW'(S_IN);
      cycle();
      idle_inputs();
   endtask

   task automatic peek(input int sel, input string tag, input logic [DW-1:0] exp);
      idle_inputs();
      src_sel = SW'(sel);
      cycle();
      check_eq(tag, bus_out, exp);
   endtask

   initial begin
      int req_cnt;
      m_reset();
      idle_inputs();
      src_sel = '0;
      inport_data = 32'h0;

      // Reset and sweep every source code with nothing written.
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      for (int s = 0; s < 32; s++) peek(s, "reset_src", 32'h0);

      // SUB: R3 = R5 = 0x12, Y = 0x0C, Z = Y - R3.
      reg_in = 16'h0028; load_in(32'h12);
      y_in = 1'b1;       load_in(32'h0C);
      src_sel = SW'(3); z_in = 1'b1; alu_op = 3'd1; cycle(); idle_inputs();
      peek(S_ZLO, "sub_zlo", 32'hFFFF_FFFA);
      peek(S_ZHI, "sub_zhi", 32'h0);
      peek(5, "r5", 32'h12);
      src_sel = SW'(S_ZLO); reg_in = 16'h0004; cycle(); idle_inputs();
      peek(2, "r2_from_zlo", 32'hFFFF_FFFA);

      // MUL: -2 * 3.
      y_in = 1'b1; load_in(32'hFFFF_FFFE);
      z_in = 1'b1; alu_op = 3'd7; load_in(32'h3);
      peek(S_ZHI, "mul_zhi", 32'hFFFF_FFFF);
      peek(S_ZLO, "mul_zlo", 32'hFFFF_FFFA);

      // Memory read with a write attempted while busy.
      mar_in = 1'b1; load_in(32'h40);
      check_eq("mar", mem_addr, 32'h40);
      req_cnt = 0;
      mem_read = 1'b1; src_sel = SW'(S_PC); cycle();
      if (mem_req) req_cnt++;
      idle_inputs();
      inport_data = 32'h55; src_sel = SW'(S_IN); reg_in = 16'h0002;
      for (int i = 0; i < 2; i++) begin
         cycle();
         if (mem_req) req_cnt++;
      end
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; cycle();
      if (mem_req) req_cnt++;
      check_eq("req_cycles", req_cnt, 32'd3);
      peek(1, "r1_dropped", 32'h0);
      peek(S_MDR, "mdr_read", 32'hDEAD_BEEF);

      // Immediate sign extension and hard-wired R0.
      ir_in = 1'b1; load_in(32'h0007_FFFF);
      peek(S_C, "c_sext", 32'hFFFF_FFFF);
      reg_in = 16'h0001; load_in(32'h5);
      peek(0, "r0_zero", 32'h0);

      // Clear during an outstanding read, then a late ack.
      mem_read = 1'b1; cycle(); idle_inputs();
      cycle();
      clear = 1'b1; cycle(); idle_inputs();
      mem_ack = 1'b1; mem_rdata = 32'h1234_5678; cycle();
      check_eq("abort_req", {31'h0, mem_req}, 32'h0);
      peek(S_MDR, "abort_mdr", 32'h0);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         idle_inputs();
         src_sel     = SW'($urandom_range(0, 31));
         inport_data = $urandom;
         mem_rdata   = $urandom;
         reg_in      = NR'($urandom & $urandom & $urandom);
         pc_in  = ($urandom_range(0, 5) == 0);
         ir_in  = ($urandom_range(0, 5) == 0);
         y_in   = ($urandom_range(0, 3) == 0);
         hi_in  = ($urandom_range(0, 5) == 0);
         lo_in  = ($urandom_range(0, 5) == 0);
         mar_in = ($urandom_range(0, 5) == 0);
         mdr_in = ($urandom_range(0, 5) == 0);
         z_in   = ($urandom_range(0, 2) == 0);
         alu_op = 3'($urandom_range(0, 7));
         mem_read = ($urandom_range(0, 7) == 0);
         mem_ack  = ($urandom_range(0, 2) == 0);
         clear    = ($urandom_range(0, 63) == 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
